// File: rtl/lcd_pkg.sv
// Shared encodings and default timing values for the LCD write-engine scheduler.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_PWR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    JOB_INIT = 2'd0,
    JOB_UPD  = 2'd1,
    JOB_REF  = 2'd2
  } job_t;

  localparam int         POWERUP_MS_DEF = 20;
  localparam int         REFRESH_MS_DEF = 500;
  localparam int         TIMEOUT_MS_DEF = 50;
  localparam logic [1:0] INIT_CNT_DEF   = 2'd3;
  localparam logic [1:0] REF_CNT_DEF    = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_ms_timer.sv
// Loadable millisecond up-counter; saturates at the terminal count and flags it on done.
module lcd_ms_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] r_cnt;

  // start has priority so a restart always lands on zero, even while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (run && (r_cnt < limit)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign done = (r_cnt == limit);

endmodule

// File: rtl/lcd_scheduler.sv
// Sequences power-up wait, init, updates and periodic refresh onto the LCD write engine.
module lcd_scheduler
  import lcd_pkg::*;
#(
  parameter int         POWERUP_MS = POWERUP_MS_DEF,
  parameter int         REFRESH_MS = REFRESH_MS_DEF,
  parameter int         TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter logic [1:0] INIT_CNT   = INIT_CNT_DEF,
  parameter logic [1:0] REF_CNT    = REF_CNT_DEF
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       reinit_req,
  input  logic       upd_req,
  input  logic [1:0] upd_cnt,
  input  logic       lcd_finish,
  output logic       mode,
  output logic [1:0] lcd_cnt,
  output logic       lcd_enable,
  output logic       upd_ack,
  output logic       busy,
  output logic       init_done,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam int           W       = $clog2(max3(POWERUP_MS, REFRESH_MS, TIMEOUT_MS));
  localparam logic [W-1:0] PWR_LIM = W'(POWERUP_MS - 1);
  localparam logic [W-1:0] TO_LIM  = W'(TIMEOUT_MS - 1);
  localparam logic [W-1:0] REF_LIM = W'(REFRESH_MS - 1);

  // Engine handshake: lcd_enable is a one-cycle start strobe with mode/lcd_cnt
  // already stable; the engine answers with a one-cycle lcd_finish, which is
  // only honoured in WAIT. No new strobe is raised until that answer or a timeout.

  state_t       r_state, w_state_nxt;
  job_t         r_job, w_job_nxt;
  logic         r_mode;
  logic [1:0]   r_lcd_cnt;
  logic         r_lcd_enable;
  logic         r_upd_ack;
  logic         r_init_done;
  logic         r_err;
  logic         w_fin;
  logic         w_timeout;
  logic         w_go_issue;
  logic         w_t1_start;
  logic         w_t1_run;
  logic [W-1:0] w_t1_limit;
  logic         w_t1_done;
  logic         w_ref_run;
  logic         w_ref_done;

  always_comb begin
    w_state_nxt = r_state;
    w_job_nxt   = r_job;
    w_fin       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_PWR: begin
        if (w_t1_done) begin
          w_state_nxt = ST_ISSUE;
          w_job_nxt   = JOB_INIT;
        end
      end
      ST_IDLE: begin
        if (reinit_req || !r_init_done) begin
          w_state_nxt = ST_ISSUE;
          w_job_nxt   = JOB_INIT;
        end else if (upd_req) begin
          w_state_nxt = ST_ISSUE;
          w_job_nxt   = JOB_UPD;
        end else if (w_ref_done) begin
          w_state_nxt = ST_ISSUE;
          w_job_nxt   = JOB_REF;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish arriving on the timeout edge still counts as a clean completion.
        if (lcd_finish) begin
          w_state_nxt = ST_IDLE;
          w_fin       = 1'b1;
        end else if (w_t1_done) begin
          w_state_nxt = ST_ISSUE;
          w_job_nxt   = JOB_INIT;
          w_timeout   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_PWR;
      end
    endcase
  end

  assign w_go_issue = (w_state_nxt == ST_ISSUE);

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_PWR;
      r_job        <= JOB_INIT;
      r_mode       <= 1'b1;
      r_lcd_cnt    <= 2'd0;
      r_lcd_enable <= 1'b0;
      r_upd_ack    <= 1'b0;
      r_init_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_job        <= w_job_nxt;
      r_lcd_enable <= w_go_issue;
      r_upd_ack    <= w_fin && (r_job == JOB_UPD);
      if (w_go_issue) begin
        case (w_job_nxt)
          JOB_INIT: begin
            r_mode    <= 1'b1;
            r_lcd_cnt <= INIT_CNT;
          end
          JOB_UPD: begin
            r_mode    <= 1'b0;
            r_lcd_cnt <= upd_cnt;
          end
          default: begin
            r_mode    <= 1'b0;
            r_lcd_cnt <= REF_CNT;
          end
        endcase
      end
      if (w_timeout) begin
        r_init_done <= 1'b0;
        r_err       <= 1'b1;
      end else if (w_fin && (r_job == JOB_INIT)) begin
        r_init_done <= 1'b1;
      end
    end
  end

  // One counter covers both the power-up wait and the WAIT watchdog; they never overlap.
  assign w_t1_start = (r_state == ST_ISSUE);
  assign w_t1_run   = (r_state == ST_PWR) || (r_state == ST_WAIT);
  assign w_t1_limit = (r_state == ST_PWR) ? PWR_LIM : TO_LIM;

  lcd_ms_timer #(.W(W)) u_pwr_wdg_timer (
    .clk   (clk_1ms),
    .rst_n (reset),
    .start (w_t1_start),
    .run   (w_t1_run),
    .limit (w_t1_limit),
    .done  (w_t1_done)
  );

  assign w_ref_run = (r_state == ST_IDLE) && r_init_done;

  lcd_ms_timer #(.W(W)) u_refresh_timer (
    .clk   (clk_1ms),
    .rst_n (reset),
    .start (w_fin),
    .run   (w_ref_run),
    .limit (REF_LIM),
    .done  (w_ref_done)
  );

  assign mode       = r_mode;
  assign lcd_cnt    = r_lcd_cnt;
  assign lcd_enable = r_lcd_enable;
  assign upd_ack    = r_upd_ack;
  assign busy       = (r_state != ST_IDLE);
  assign init_done  = r_init_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_scheduler.sv
// Self-checking bench for lcd_scheduler: expected jobs queued at stimulus, checked at each lcd_enable.
module tb_lcd_scheduler;
  import lcd_pkg::*;

  logic       clk_1ms = 1'b0;
  logic       reset = 1'b1;
  logic       reinit_req = 1'b0;
  logic       upd_req = 1'b0;
  logic [1:0] upd_cnt = 2'd0;
  logic       lcd_finish = 1'b0;
  logic       mode;
  logic [1:0] lcd_cnt;
  logic       lcd_enable;
  logic       upd_ack;
  logic       busy;
  logic       init_done;
  logic       err;
  logic [1:0] dbg_state;

  lcd_scheduler dut (
    .clk_1ms    (clk_1ms),
    .reset      (reset),
    .reinit_req (reinit_req),
    .upd_req    (upd_req),
    .upd_cnt    (upd_cnt),
    .lcd_finish (lcd_finish),
    .mode       (mode),
    .lcd_cnt    (lcd_cnt),
    .lcd_enable (lcd_enable),
    .upd_ack    (upd_ack),
    .busy       (busy),
    .init_done  (init_done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock/reset
  always #5 clk_1ms = ~clk_1ms;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  // scoreboard: {mode, lcd_cnt} expected for each lcd_enable strobe
  localparam logic [2:0] EXP_INIT = 3'b111;
  localparam logic [2:0] EXP_REF  = 3'b011;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_exp = EXP_INIT;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_1ms) begin
    if (lcd_enable) begin
      if (exp_q.size() == 0) begin
        check_eq("enable_expected", exp_q.size(), 1);
      end else begin
        last_exp = exp_q.pop_front();
        check_eq("issue_job", {mode, lcd_cnt}, last_exp);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_1ms);
  endtask

  task automatic wait_enable(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk_1ms);
      n++;
    end while (!lcd_enable && n < max);
    check_eq("enable_seen", lcd_enable, 1);
  endtask

  task automatic pulse_finish();
    check_eq("hold_job", {mode, lcd_cnt}, last_exp);
    lcd_finish = 1'b1;
    tick();
    lcd_finish = 1'b0;
  endtask

  task automatic run_update(input logic [1:0] c, input int d);
    int n;
    upd_cnt = c;
    upd_req = 1'b1;
    exp_q.push_back({1'b0, c});
    wait_enable(5, n);
    check_eq("upd_latency", n, 1);
    upd_req = 1'b0;
    upd_cnt = ~c;
    tick(d);
    pulse_finish();
    check_eq("upd_ack_hi", upd_ack, 1);
    check_eq("idle_after_upd", busy, 0);
    tick();
    check_eq("upd_ack_lo", upd_ack, 0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    tick(3);
    check_eq("rst_mode", mode, 1);
    check_eq("rst_cnt", lcd_cnt, 0);
    check_eq("rst_enable", lcd_enable, 0);
    check_eq("rst_ack", upd_ack, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_state", dbg_state, ST_PWR);

    // power-up then init; a finish during ISSUE must be ignored
    exp_q.push_back(EXP_INIT);
    reset = 1'b1;
    wait_enable(40, n);
    check_eq("pwr_latency", n, 20);
    lcd_finish = 1'b1;
    tick();
    lcd_finish = 1'b0;
    check_eq("finish_in_issue_busy", busy, 1);
    tick(4);
    pulse_finish();
    check_eq("init_done_set", init_done, 1);
    check_eq("init_idle", busy, 0);
    check_eq("init_no_ack", upd_ack, 0);
    check_eq("init_state", dbg_state, ST_IDLE);

    lcd_finish = 1'b1;
    tick();
    lcd_finish = 1'b0;
    check_eq("finish_in_idle_ack", upd_ack, 0);
    check_eq("finish_in_idle_busy", busy, 0);

    run_update(2'd2, 3);
    for (int i = 0; i < 4; i++) begin
      run_update(2'($urandom_range(0, 3)), $urandom_range(1, 8));
    end

    // refresh after REFRESH_MS idle cycles (one already spent on the ack fall)
    exp_q.push_back(EXP_REF);
    wait_enable(600, n);
    check_eq("refresh_latency", n, 499);
    tick(2);
    pulse_finish();
    check_eq("refresh_no_ack", upd_ack, 0);

    // an update completing 300 cycles in restarts the refresh interval
    tick(299);
    run_update(2'd1, 2);
    exp_q.push_back(EXP_REF);
    wait_enable(600, n);
    check_eq("refresh_delayed", n, 499);
    tick(2);
    pulse_finish();

    // reinit beats update; update follows right after; reinit raised while busy
    reinit_req = 1'b1;
    upd_req = 1'b1;
    upd_cnt = 2'd1;
    exp_q.push_back(EXP_INIT);
    exp_q.push_back(3'b001);
    wait_enable(5, n);
    check_eq("reinit_first", n, 1);
    reinit_req = 1'b0;
    tick(2);
    pulse_finish();
    check_eq("reinit_idle", busy, 0);
    wait_enable(5, n);
    check_eq("upd_after_init", n, 1);
    upd_req = 1'b0;
    reinit_req = 1'b1;
    exp_q.push_back(EXP_INIT);
    tick(2);
    pulse_finish();
    check_eq("upd_ack_before_reinit", upd_ack, 1);
    wait_enable(5, n);
    check_eq("reinit_after_busy", n, 1);
    reinit_req = 1'b0;
    tick(2);
    pulse_finish();

    // finish on the exact timeout edge wins
    upd_cnt = 2'd3;
    upd_req = 1'b1;
    exp_q.push_back(3'b011);
    wait_enable(5, n);
    upd_req = 1'b0;
    tick(50);
    pulse_finish();
    check_eq("edge_finish_err", err, 0);
    check_eq("edge_finish_ack", upd_ack, 1);
    check_eq("edge_finish_init", init_done, 1);
    tick();

    // watchdog timeout
    upd_cnt = 2'd0;
    upd_req = 1'b1;
    exp_q.push_back(3'b000);
    wait_enable(5, n);
    upd_req = 1'b0;
    exp_q.push_back(EXP_INIT);
    n = 0;
    do begin
      tick();
      n++;
    end while (!err && n < 80);
    check_eq("timeout_latency", n, 51);
    check_eq("timeout_reinit_enable", lcd_enable, 1);
    check_eq("timeout_init_cleared", init_done, 0);
    check_eq("timeout_no_ack", upd_ack, 0);
    tick(3);
    pulse_finish();
    check_eq("reinit_after_timeout", init_done, 1);
    check_eq("err_sticky", err, 1);
    check_eq("lost_upd_no_ack", upd_ack, 0);
    tick();

    // reset in the middle of a job
    upd_cnt = 2'd2;
    upd_req = 1'b1;
    exp_q.push_back(3'b010);
    wait_enable(5, n);
    upd_req = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_mode", mode, 1);
    check_eq("mid_rst_cnt", lcd_cnt, 0);
    check_eq("mid_rst_enable", lcd_enable, 0);
    check_eq("mid_rst_busy", busy, 1);
    check_eq("mid_rst_init_done", init_done, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_state", dbg_state, ST_PWR);
    tick(2);
    exp_q.push_back(EXP_INIT);
    reset = 1'b1;
    wait_enable(40, n);
    check_eq("repower_latency", n, 20);
    tick(2);
    pulse_finish();
    check_eq("repower_init_done", init_done, 1);
    check_eq("repower_err", err, 0);

    tick(2);
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
